alu_top: RTL and testbench

Multi-cycle 8-bit signed ALU with a start/done handshake and a 16-bit result. Accepts two's-complement operands and an opcode, performs add, subtract, multiply, divide, AND, OR or XOR, and reports completion with a one-cycle `done` pulse. It is the top-level ALU block driven by a controller that issues one operation at a time.

---
 rtl/alu_top.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_top.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_top.sv
// -----------------------------------------------------------------------------
// alu_top : multi-cycle 8-bit signed ALU with start/done handshake.
//
// Operations (op): 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR,
//                  110 XOR, 111 reserved (result 0).
// Arithmetic is signed on 16 bits with sign-extended operands; the bitwise
// ops work on 8 bits and zero-extend. MUL is an 8-step shift-add unit, DIV an
// 8-step restoring divider on magnitudes followed by sign correction.
//
// Optional feature macro: ALU_DIV_EN. When undefined the divider is not built
// and op 011 behaves like the reserved opcode (single cycle, result 0).
//
// Ports:
//   clk     in   1  rising-edge clock
//   reset   in   1  asynchronous active-high reset
//   start   in   1  request, sampled only in IDLE
//   op      in   3  opcode
//   in_a    in   8  operand A (two's complement)
//   in_b    in   8  operand B (two's complement)
//   done    out  1  one-cycle completion pulse (high for the DONE state)
//   result  out 16  registered result, held until the next completion
// -----------------------------------------------------------------------------
module alu_top (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        done,
  output logic [15:0] result
);

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
`ifdef ALU_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b011;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic accept;
  logic finish;
  logic iter_op;

  // Operands latched at the accepting edge
  logic [2:0]               op_p0;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic [3:0]               cnt;

  // Shift-add multiplier state
  logic signed [RES_W-1:0]  acc;
  logic signed [RES_W-1:0]  mcand;
  logic [DATA_W-1:0]        mplier;

`ifdef ALU_DIV_EN
  // Restoring divider state (magnitudes)
  logic [DATA_W-1:0]        rem;
  logic [DATA_W-1:0]        dq;
  logic [DATA_W-1:0]        dvs;
  logic                     q_neg;
  logic [DATA_W:0]          rem_sh;
  logic                     q_bit;
  logic [DATA_W-1:0]        rem_nxt;
`endif

  function automatic logic signed [RES_W-1:0] sext(input logic [DATA_W-1:0] x);
    sext = {{(RES_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  function automatic logic [RES_W-1:0] simple_op(input logic [2:0] o,
                                                 input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
    logic signed [RES_W-1:0] ax;
    logic signed [RES_W-1:0] bx;
    ax = sext(a);
    bx = sext(b);
    case (o)
      OP_ADD:  simple_op = ax + bx;
      OP_SUB:  simple_op = ax - bx;
      OP_AND:  simple_op = {8'h00, a & b};
      OP_OR:   simple_op = {8'h00, a | b};
      OP_XOR:  simple_op = {8'h00, a ^ b};
      default: simple_op = '0;
    endcase
  endfunction

`ifdef ALU_DIV_EN
  function automatic logic [DATA_W-1:0] abs8(input logic [DATA_W-1:0] x);
    abs8 = x[DATA_W-1] ? (~x + 8'd1) : x;
  endfunction

  // Apply the quotient sign; a zero divisor yields all ones.
  function automatic logic [RES_W-1:0] div_fix(input logic [DATA_W-1:0] q,
                                               input logic neg,
                                               input logic dvz);
    logic [RES_W-1:0] mag;
    mag = {8'h00, q};
    if (dvz)
      div_fix = 16'hFFFF;
    else
      div_fix = neg ? (~mag + 16'd1) : mag;
  endfunction

  always_comb begin
    rem_sh  = {rem, dq[DATA_W-1]};
    q_bit   = (rem_sh >= {1'b0, dvs});
    rem_nxt = q_bit ? 8'(rem_sh - {1'b0, dvs}) : rem_sh[DATA_W-1:0];
  end

  assign iter_op = (op_p0 == OP_MUL) || (op_p0 == OP_DIV);
`else
  assign iter_op = (op_p0 == OP_MUL);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // Iterative ops spend eight edges stepping, then write on the ninth.
        if (!iter_op || (cnt == 4'd8)) begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_p0  <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      result <= '0;
`ifdef ALU_DIV_EN
      rem    <= '0;
      dq     <= '0;
      dvs    <= '0;
      q_neg  <= 1'b0;
`endif
    end else if (accept) begin
      // p0: capture operands and seed both iterative units
      op_p0  <= op;
      a_p0   <= in_a;
      b_p0   <= in_b;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= sext(in_a);
      mplier <= in_b;
`ifdef ALU_DIV_EN
      rem    <= '0;
      dq     <= abs8(in_a);
      dvs    <= abs8(in_b);
      q_neg  <= in_a[DATA_W-1] ^ in_b[DATA_W-1];
`endif
    end else if (finish) begin
      if (op_p0 == OP_MUL)
        result <= acc;
`ifdef ALU_DIV_EN
      else if (op_p0 == OP_DIV)
        result <= div_fix(dq, q_neg, (dvs == 8'd0));
`endif
      else
        result <= simple_op(op_p0, a_p0, b_p0);
    end else if (state == S_BUSY) begin
      cnt <= cnt + 4'd1;
      if (op_p0 == OP_MUL) begin
        // Bit 7 of the multiplier carries weight -128, so it subtracts.
        if (mplier[0])
          acc <= (cnt == 4'd7) ? (acc - mcand) : (acc + mcand);
        mcand  <= mcand <<< 1;
        mplier <= mplier >> 1;
      end
`ifdef ALU_DIV_EN
      if (op_p0 == OP_DIV) begin
        rem <= rem_nxt;
        dq  <= {dq[DATA_W-2:0], q_bit};
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_top.sv
module tb_alu_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        done;
  logic [15:0] result;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

`ifdef ALU_DIV_EN
  localparam int DIV_LAT = 9;
`else
  localparam int DIV_LAT = 1;
`endif

  alu_top dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .in_a   (in_a),
    .in_b   (in_b),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one operation, measure edges from the accepting edge to done,
  // compare against the scoreboard, then confirm done drops and result holds.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] expv, input int lat,
                        input bit poke);
    int n;
    logic [15:0] e;
    @(negedge clk);
    op = o; in_a = a; in_b = b; start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    start = 1'b0;
    in_a  = 8'($urandom);
    in_b  = 8'($urandom);
    op    = 3'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (poke && n == 3) begin
        start = 1'b1; op = 3'b000; in_a = 8'd5; in_b = 8'd6;
      end
      if (poke && n == 5) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check_int({tag, " latency"}, n, lat);
    check16({tag, " result"}, result, e);
    @(posedge clk); #1;
    check1({tag, " done pulse width"}, done, 1'b0);
    check16({tag, " result held"}, result, e);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; op = '0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check1("reset done", done, 1'b0);
    check16("reset result", result, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    check1("no spurious done", seen, 1'b0);
    check16("result after release", result, 16'h0000);

    run_op("add 127+1",   3'b000, 8'd127, 8'd1,   16'h0080, 1, 1'b0);
    run_op("add -128+-1", 3'b000, 8'h80,  8'hFF,  16'hFF7F, 1, 1'b0);
    run_op("sub 127-127", 3'b001, 8'd127, 8'd127, 16'h0000, 1, 1'b0);
    run_op("sub -50-25",  3'b001, 8'hCE,  8'd25,  16'hFFB5, 1, 1'b0);
    run_op("sub 50--25",  3'b001, 8'd50,  8'hE7,  16'h004B, 1, 1'b0);

    run_op("mul 127x2",   3'b010, 8'd127, 8'd2,   16'h00FE, 9, 1'b0);
    run_op("mul -10x-10", 3'b010, 8'hF6,  8'hF6,  16'h0064, 9, 1'b0);
    run_op("mul 1x-128",  3'b010, 8'd1,   8'h80,  16'hFF80, 9, 1'b0);
    run_op("mul -1x-128", 3'b010, 8'hFF,  8'h80,  16'h0080, 9, 1'b0);
    run_op("mul 10x-10",  3'b010, 8'd10,  8'hF6,  16'hFF9C, 9, 1'b0);

`ifdef ALU_DIV_EN
    run_op("div 127/1",     3'b011, 8'd127, 8'd1,  16'h007F, DIV_LAT, 1'b0);
    run_op("div 100/-10",   3'b011, 8'd100, 8'hF6, 16'hFFF6, DIV_LAT, 1'b0);
    run_op("div -100/-10",  3'b011, 8'h9C,  8'hF6, 16'h000A, DIV_LAT, 1'b0);
    run_op("div -100/10",   3'b011, 8'h9C,  8'd10, 16'hFFF6, DIV_LAT, 1'b0);
    run_op("div 7/-2",      3'b011, 8'd7,   8'hFE, 16'hFFFD, DIV_LAT, 1'b0);
    run_op("div -128/-1",   3'b011, 8'h80,  8'hFF, 16'h0080, DIV_LAT, 1'b0);
    run_op("div 10/0",      3'b011, 8'd10,  8'd0,  16'hFFFF, DIV_LAT, 1'b0);
    run_op("div 0/0",       3'b011, 8'd0,   8'd0,  16'hFFFF, DIV_LAT, 1'b0);
`else
    run_op("div 127/1 off",    3'b011, 8'd127, 8'd1,  16'h0000, DIV_LAT, 1'b0);
    run_op("div 100/-10 off",  3'b011, 8'd100, 8'hF6, 16'h0000, DIV_LAT, 1'b0);
    run_op("div -100/-10 off", 3'b011, 8'h9C,  8'hF6, 16'h0000, DIV_LAT, 1'b0);
    run_op("div 10/0 off",     3'b011, 8'd10,  8'd0,  16'h0000, DIV_LAT, 1'b0);
`endif

    run_op("and aa,55",   3'b100, 8'hAA, 8'h55, 16'h0000, 1, 1'b0);
    run_op("or aa,55",    3'b101, 8'hAA, 8'h55, 16'h00FF, 1, 1'b0);
    run_op("xor aa,55",   3'b110, 8'hAA, 8'h55, 16'h00FF, 1, 1'b0);
    run_op("and f0,aa",   3'b100, 8'hF0, 8'hAA, 16'h00A0, 1, 1'b0);
    run_op("reserved",    3'b111, 8'd12, 8'd34, 16'h0000, 1, 1'b0);

    run_op("mul busy poke", 3'b010, 8'd7, 8'hFD, 16'hFFEB, 9, 1'b1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    check1("busy start ignored", seen, 1'b0);

    run_op("or before reset", 3'b101, 8'h0F, 8'h30, 16'h003F, 1, 1'b0);

    // Abort a divide with reset after its fourth cycle.
    @(negedge clk);
    op = 3'b011; in_a = 8'd100; in_b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check1("abort done", done, 1'b0);
    check16("abort result", result, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    check1("no done after abort", seen, 1'b0);
    check16("result after abort", result, 16'h0000);

    run_op("add 1+1 after abort", 3'b000, 8'd1, 8'd1, 16'h0002, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
